bcd_display_controller: RTL and testbench

Sequencing and scan controller for the digital timer's display path. It shares one combinational binary-to-BCD converter between the seconds and minutes counters, converting each value in turn. It commits both results atomically to a display register set. It then time-multiplexes the four resulting BCD digits onto a common-bus 7-segment display, one digit per scan slot.

---
 rtl/bcd_display_controller.sv | 131 +++++++++++++
 tb/tb_bcd_display_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_controller.sv
// Sequences one shared binary-to-BCD converter over seconds then minutes, commits both atomically,
// and scans the four digits onto a common-bus display. Optional: BCD_BLANK_LEADING_ZERO_EN.
module bcd_display_controller #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sec_value,
  input  logic [7:0] min_value,
  input  logic       update,
  output logic [7:0] conv_binary,
  input  logic [3:0] conv_tens,
  input  logic [3:0] conv_ones,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit_en,
  output logic [3:0] digit_bcd
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEC    = 2'd1,
    S_MIN    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_conv_binary;
  logic [7:0]       r_sec_shadow;
  logic [7:0]       r_min_shadow;
  logic [7:0]       r_disp_sec;
  logic [7:0]       r_disp_min;
  logic             r_pending;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_digit_idx;

  function automatic logic [7:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Conversion sequencer; shadows isolate the display from half-finished conversions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_conv_binary <= 8'd0;
      r_sec_shadow  <= 8'd0;
      r_min_shadow  <= 8'd0;
      r_disp_sec    <= 8'd0;
      r_disp_min    <= 8'd0;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (update) begin
            r_state       <= S_SEC;
            r_conv_binary <= sat99(sec_value);
            r_busy        <= 1'b1;
          end
        end
        S_SEC: begin
          r_sec_shadow  <= {conv_tens, conv_ones};
          r_conv_binary <= sat99(min_value);
          r_state       <= S_MIN;
          if (update) r_pending <= 1'b1;
        end
        S_MIN: begin
          r_min_shadow <= {conv_tens, conv_ones};
          r_state      <= S_COMMIT;
          if (update) r_pending <= 1'b1;
        end
        S_COMMIT: begin
          r_disp_sec <= r_sec_shadow;
          r_disp_min <= r_min_shadow;
          r_done     <= 1'b1;
          r_pending  <= 1'b0;
          if (update || r_pending) begin
            r_state       <= S_SEC;
            r_conv_binary <= sat99(sec_value);
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Free-running scan, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    digit_en  = 4'b0001;
    digit_bcd = 4'd0;
    case (r_digit_idx)
      2'd0: begin digit_en = 4'b0001; digit_bcd = r_disp_sec[3:0]; end
      2'd1: begin digit_en = 4'b0010; digit_bcd = r_disp_sec[7:4]; end
      2'd2: begin digit_en = 4'b0100; digit_bcd = r_disp_min[3:0]; end
      2'd3: begin
        digit_en  = 4'b1000;
        digit_bcd = r_disp_min[7:4];
`ifdef BCD_BLANK_LEADING_ZERO_EN
        if (r_disp_min[7:4] == 4'd0) digit_en = 4'b0000;
`endif
      end
      default: ;
    endcase
  end

  assign conv_binary = r_conv_binary;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_bcd_display_controller.sv
// Self-checking bench for bcd_display_controller with a behavioural converter and display model.
module tb_bcd_display_controller;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sec_value = 8'd0;
  logic [7:0] min_value = 8'd0;
  logic       update = 1'b0;
  logic [7:0] conv_binary;
  logic [3:0] conv_tens;
  logic [3:0] conv_ones;
  logic       busy;
  logic       done;
  logic [3:0] digit_en;
  logic [3:0] digit_bcd;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  int m_sec = 0;
  int m_min = 0;

  bcd_display_controller #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .sec_value(sec_value), .min_value(min_value),
    .update(update), .conv_binary(conv_binary), .conv_tens(conv_tens),
    .conv_ones(conv_ones), .busy(busy), .done(done), .digit_en(digit_en),
    .digit_bcd(digit_bcd)
  );

  always #5 clk = ~clk;

  // External converter: decimal digits of the operand, hundreds discarded.
  assign conv_tens = 4'((int'(conv_binary) / 10) % 10);
  assign conv_ones = 4'(int'(conv_binary) % 10);

  // Elapsed cycles since reset drive the expected scan slot.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic int slot();
    return int'((cyc / SD) % 4);
  endfunction

  function automatic logic [3:0] exp_en();
    logic [3:0] e;
    e = 4'(1 << slot());
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (slot() == 3 && (m_min / 10) == 0) e = 4'b0000;
`endif
    return e;
  endfunction

  function automatic logic [3:0] exp_bcd();
    case (slot())
      0:       return 4'(m_sec % 10);
      1:       return 4'(m_sec / 10);
      2:       return 4'(m_min % 10);
      default: return 4'(m_min / 10);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (conv_binary !== 8'd0) $display("FAIL reset_conv got %0d want 0", conv_binary); else n_pass++;
    n_total++; if (digit_en !== 4'b0001) $display("FAIL reset_en got %b want 0001", digit_en); else n_pass++;
    n_total++; if (digit_bcd !== 4'd0) $display("FAIL reset_bcd got %0d want 0", digit_bcd); else n_pass++;
    for (int i = 0; i < int'(4 * SD); i++) begin
      tick();
      n_total++; if (digit_en !== exp_en()) $display("FAIL idle_en cyc %0d got %b want %b", cyc, digit_en, exp_en()); else n_pass++;
      n_total++; if (digit_bcd !== 4'd0) $display("FAIL idle_bcd cyc %0d got %0d want 0", cyc, digit_bcd); else n_pass++;
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_ctl got busy %b done %b want 0 0", busy, done); else n_pass++;
    end
  endtask

  task automatic test_conversion(input int s, input int m);
    sec_value = 8'(s);
    min_value = 8'(m);
    update = 1'b1;
    tick();  // edge k
    update = 1'b0;
    n_total++; if (conv_binary !== 8'(sat(s))) $display("FAIL conv_sec got %0d want %0d", conv_binary, sat(s)); else n_pass++;
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL k_ctl got busy %b done %b want 1 0", busy, done); else n_pass++;
    tick();  // k+1
    n_total++; if (conv_binary !== 8'(sat(m))) $display("FAIL conv_min got %0d want %0d", conv_binary, sat(m)); else n_pass++;
    sec_value = 8'($urandom_range(0, 255));
    min_value = 8'($urandom_range(0, 255));
    tick();  // k+2
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL k2_ctl got busy %b done %b want 1 0", busy, done); else n_pass++;
    n_total++; if (digit_bcd !== exp_bcd()) $display("FAIL k2_old_disp got %0d want %0d", digit_bcd, exp_bcd()); else n_pass++;
    tick();  // k+3
    m_sec = sat(s);
    m_min = sat(m);
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL commit_ctl got done %b busy %b want 1 0", done, busy); else n_pass++;
    n_total++; if (digit_bcd !== exp_bcd()) $display("FAIL commit_disp got %0d want %0d", digit_bcd, exp_bcd()); else n_pass++;
    for (int i = 0; i < int'(4 * SD); i++) begin
      tick();
      n_total++; if (done !== 1'b0) $display("FAIL done_len got %b want 0", done); else n_pass++;
      n_total++; if (digit_en !== exp_en()) $display("FAIL scan_en slot %0d got %b want %b", slot(), digit_en, exp_en()); else n_pass++;
      n_total++; if (digit_bcd !== exp_bcd()) $display("FAIL scan_bcd slot %0d got %0d want %0d", slot(), digit_bcd, exp_bcd()); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    sec_value = 8'd10;
    min_value = 8'd20;
    update = 1'b1;
    tick();  // k
    tick();  // k+1, update while busy
    sec_value = 8'd45;
    tick();  // k+2, second update coalesces
    update = 1'b0;
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_k2 got busy %b done %b want 1 0", busy, done); else n_pass++;
    tick();  // k+3, commit and restart
    m_sec = 10;
    m_min = 20;
    n_total++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL b2b_first got done %b busy %b want 1 1", done, busy); else n_pass++;
    n_total++; if (conv_binary !== 8'd45) $display("FAIL b2b_restart_conv got %0d want 45", conv_binary); else n_pass++;
    n_total++; if (digit_bcd !== exp_bcd()) $display("FAIL b2b_first_disp got %0d want %0d", digit_bcd, exp_bcd()); else n_pass++;
    tick();
    n_total++; if (conv_binary !== 8'd20 || busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_k4 got conv %0d busy %b done %b want 20 1 0", conv_binary, busy, done); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_k5 got busy %b done %b want 1 0", busy, done); else n_pass++;
    tick();
    m_sec = 45;
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_second got done %b busy %b want 1 0", done, busy); else n_pass++;
    for (int i = 0; i < int'(4 * SD); i++) begin
      tick();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_extra got busy %b done %b want 0 0", busy, done); else n_pass++;
      n_total++; if (digit_bcd !== exp_bcd()) $display("FAIL b2b_scan slot %0d got %0d want %0d", slot(), digit_bcd, exp_bcd()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    sec_value = 8'd88;
    min_value = 8'd77;
    update = 1'b1;
    tick();  // k
    update = 1'b0;
    tick();  // k+1
    reset = 1'b1;
    tick();  // k+2 reset sampled
    reset = 1'b0;
    m_sec = 0;
    m_min = 0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_ctl got busy %b done %b want 0 0", busy, done); else n_pass++;
    n_total++; if (conv_binary !== 8'd0) $display("FAIL rst_mid_conv got %0d want 0", conv_binary); else n_pass++;
    n_total++; if (digit_en !== 4'b0001 || digit_bcd !== 4'd0) $display("FAIL rst_mid_disp got en %b bcd %0d want 0001 0", digit_en, digit_bcd); else n_pass++;
    for (int i = 0; i < int'(4 * SD); i++) begin
      tick();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_after got busy %b done %b want 0 0", busy, done); else n_pass++;
      n_total++; if (digit_en !== exp_en() || digit_bcd !== 4'd0) $display("FAIL rst_mid_scan got en %b bcd %0d want %b 0", digit_en, digit_bcd, exp_en()); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_conversion(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    test_reset();
    test_conversion(37, 12);
    test_conversion(200, 150);
    test_back_to_back();
    test_reset_mid();
    test_conversion(33, 5);
    test_conversion(33, 15);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
